// File: rtl/hex_display_driver.sv
// Binary-to-decimal driver for eight active-low seven-segment displays (HEX7..HEX0).
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module hex_display_driver #(
   parameter int BIN_W  = 27,
   parameter int DIGITS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] din,
   input  logic        din_we,
   output logic        busy,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [6:0]  hex6,
   output logic [6:0]  hex7
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CAT_W = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
   localparam logic [31:0] MAX_DEC = 32'd99_999_999;

   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] SEG_RST_UPPER = SEG_BLANK;
`else
   localparam logic [6:0] SEG_RST_UPPER = SEG_ZERO;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_r;
   state_t              next_state_s;
   logic                load_s;
   logic [31:0]         load_val_s;
   logic [BIN_W-1:0]    bin_r;
   logic [BCD_W-1:0]    bcd_r;
   logic [BCD_W-1:0]    adj_s;
   logic [CAT_W-1:0]    shifted_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                ovf_r;
   logic                pend_r;
   logic [31:0]         pend_val_r;
   logic                busy_r;
   logic [6:0]          hex_r      [DIGITS];
   logic [6:0]          seg_next_s [DIGITS];
   logic [3:0]          digit_s;
`ifdef LEADING_ZERO_BLANK_EN
   logic                lead_s;
`endif

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end else begin
            res[4*i +: 4] = bcd[4*i +: 4];
         end
      end
      return res;
   endfunction

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] seg;
      case (d)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next state and conversion-start selection; a same-cycle strobe beats the pending value.
   always_comb begin
      next_state_s = state_r;
      load_s       = 1'b0;
      load_val_s   = din;
      case (state_r)
         IDLE: begin
            if (din_we) begin
               next_state_s = SHIFT;
               load_s       = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_r == LAST_SHIFT) begin
               next_state_s = DONE;
            end else begin
               next_state_s = SHIFT;
            end
         end
         DONE: begin
            if (din_we) begin
               next_state_s = SHIFT;
               load_s       = 1'b1;
            end else if (pend_r) begin
               next_state_s = SHIFT;
               load_s       = 1'b1;
               load_val_s   = pend_val_r;
            end else begin
               next_state_s = IDLE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // One adjust-and-shift step of the BCD/binary pair.
   always_comb begin
      adj_s     = dabble_adjust(bcd_r);
      shifted_s = {adj_s, bin_r} << 1;
   end

   // Conversion datapath, pending slot and busy flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_r      <= '0;
         bcd_r      <= '0;
         cnt_r      <= '0;
         ovf_r      <= 1'b0;
         pend_r     <= 1'b0;
         pend_val_r <= 32'd0;
         busy_r     <= 1'b0;
      end else begin
         if (load_s) begin
            bin_r <= load_val_s[BIN_W-1:0];
            ovf_r <= (load_val_s > MAX_DEC);
            bcd_r <= '0;
            cnt_r <= '0;
         end else if (state_r == SHIFT) begin
            bcd_r <= shifted_s[CAT_W-1:BIN_W];
            bin_r <= shifted_s[BIN_W-1:0];
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if ((state_r == DONE) && din_we) begin
            pend_r <= 1'b0;
         end else if ((state_r != IDLE) && din_we) begin
            pend_r     <= 1'b1;
            pend_val_r <= din;
         end else if (state_r == DONE) begin
            pend_r <= 1'b0;
         end
         busy_r <= (next_state_s != IDLE);
      end
   end

   // Segment image of the finished BCD value, scanned from the top digit for blanking.
   always_comb begin
      seg_next_s = '{default: SEG_BLANK};
      digit_s    = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
      lead_s     = 1'b1;
`endif
      for (int i = DIGITS - 1; i >= 0; i--) begin
         digit_s = bcd_r[4*i +: 4];
         if (ovf_r) begin
            seg_next_s[i] = SEG_DASH;
         end else begin
`ifdef LEADING_ZERO_BLANK_EN
            if (lead_s && (digit_s == 4'd0) && (i != 0)) begin
               seg_next_s[i] = SEG_BLANK;
            end else begin
               lead_s        = 1'b0;
               seg_next_s[i] = seg_encode(digit_s);
            end
`else
            seg_next_s[i] = seg_encode(digit_s);
`endif
         end
      end
   end

   // Display registers: only DONE updates them, so the panel never shows a partial result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hex_r[0] <= SEG_ZERO;
         for (int i = 1; i < DIGITS; i++) begin
            hex_r[i] <= SEG_RST_UPPER;
         end
      end else if (state_r == DONE) begin
         for (int i = 0; i < DIGITS; i++) begin
            hex_r[i] <= seg_next_s[i];
         end
      end
   end

   assign busy = busy_r;
   assign hex0 = hex_r[0];
   assign hex1 = hex_r[1];
   assign hex2 = hex_r[2];
   assign hex3 = hex_r[3];
   assign hex4 = hex_r[4];
   assign hex5 = hex_r[5];
   assign hex6 = hex_r[6];
   assign hex7 = hex_r[7];

endmodule
